branch_commit_updater: RTL and testbench
========================================

Name: branch_commit_updater

Overview:
- Sits on the ReorderBuffer commit side and is the producer of the predictor update interface: `ROB_input_valid`, `ROB_hit`, `ROB_pc`.
- Accepts up to two committed instructions per cycle. Keeps only conditional branches and buffers their outcomes in a small FIFO.
- Drains the FIFO one update per cycle into the 2-bit counter table.
- Detects mispredicted branches and issues a one-cycle flush/redirect to InstFetcher.

Parameters:
- QUEUE_DEPTH, 4: FIFO entries; power of two, ≥2.
- ADDR_WIDTH, 32: pc width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- rdy  input  1  global ready; low = freeze all state.
- c0_valid  input  1  commit slot 0 valid (slot 0 is older).
- c0_is_branch  input  1  slot 0 is a conditional branch (`OPCODE_B`).
- c0_pc  input  ADDR_WIDTH  slot 0 instruction pc.
- c0_taken  input  1  slot 0 resolved direction.
- c0_pred_taken  input  1  slot 0 direction predicted at fetch.
- c0_target  input  ADDR_WIDTH  slot 0 resolved taken target.
- c1_valid, c1_is_branch, c1_pc, c1_taken, c1_pred_taken, c1_target: same as slot 0, for slot 1 (younger).
- commit_ready  output  1  ROB may present commits this cycle.
- ROB_input_valid  output  1  predictor update strobe.
- ROB_hit  output  1  branch taken (1 = counter increments).
- ROB_pc  output  ADDR_WIDTH  branch pc to update.
- IF_flush  output  1  mispredict flush pulse.
- IF_redirect_pc  output  ADDR_WIDTH  correct next pc.

Behaviour:
- Reset (synchronous, active-high): head = tail = count = 0. `ROB_input_valid` = 0, `ROB_hit` = 0, `ROB_pc` = 0, `IF_flush` = 0, `IF_redirect_pc` = 0. Reset mid-operation discards all queued entries, with no further updates.
- `rdy` = 0: no state or output register changes. Commits presented that cycle are ignored; ROB must hold them.
- `commit_ready` = (QUEUE_DEPTH − count ≥ 2). Combinational from the registered count. Commits with `commit_ready` = 0 are ignored.
- Slot qualification: a slot is a push candidate iff valid & is_branch & `commit_ready` & `rdy`.
- Slot mispredict: the slot qualifies & (taken != pred_taken).
- If slot 0 mispredicts, slot 1 is dropped: no push, no flush evaluation.
- Push order: slot 0 first, then slot 1. 0, 1 or 2 pushes per cycle; tail advances modulo QUEUE_DEPTH.
- Pop:
  - When count > 0 (pre-push value), the head entry is registered onto `ROB_input_valid`/`ROB_hit`/`ROB_pc` and head advances.
  - `ROB_input_valid` is a one-cycle pulse per entry, else 0. `ROB_pc`/`ROB_hit` hold their last value while invalid.
  - Update latency: an entry pushed into an empty queue at cycle N drives `ROB_input_valid` at N+2 (stored at N, popped N+1, output registered).
- Simultaneous push and pop: count_next = count + pushes − pop. Never overflows, because ready guarantees 2 free slots.
- Flush:
  - `IF_flush` is registered and pulses exactly one cycle after the commit cycle of the oldest mispredicted slot.
  - `IF_redirect_pc` = taken ? target : pc + 4, truncated to ADDR_WIDTH (wraps at 2^ADDR_WIDTH).
  - A flush does not clear the queue: committed outcomes are architectural and still drain.
- Non-branch valid slots are consumed without effect.

Optional Feature:
- BRANCH_STATS_EN: adds 32-bit output ports `stat_branches` and `stat_mispredicts`, reset to 0.
  - `stat_branches` increments by the number of pushes per cycle.
  - `stat_mispredicts` increments by 1 per flush pulse.
  - Both saturate at 0xFFFFFFFF and freeze when `rdy` = 0.
- Without the macro: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then a single c0 branch with pc=0x100, taken=1, pred=1 → `ROB_input_valid` pulse 2 cycles later with `ROB_pc`=0x100, `ROB_hit`=1; `IF_flush` stays 0.
- c0 branch pc=0x200, taken=0, pred=1 → next cycle `IF_flush`=1, `IF_redirect_pc`=0x204; update with `ROB_hit`=0 follows.
- Both slots mispredict (c0 pc=0x300, taken=1, target=0x400; c1 pc=0x304) → one flush, redirect 0x400; only 0x300 update emitted.
- Two branches pushed every cycle with depth 4 → `commit_ready` falls to 0 at count 3; updates emitted back-to-back in pc order; no entry lost or duplicated.
- Queue holding 3 entries, `rdy` low for 5 cycles, then high → outputs frozen during stall; 3 consecutive pulses resume. Assert `rst` mid-drain → outputs 0 next cycle, no further pulses.
- c0 branch pc=0xFFFFFFFC, taken=0, pred=1 → `IF_redirect_pc`=0x00000000.

Source files
------------

// File: rtl/branch_commit_updater.sv
// Commit-side branch outcome queue feeding the 2-bit predictor and mispredict flush.
// Optional BRANCH_STATS_EN adds saturating branch/mispredict counters.
module branch_commit_updater #(
    parameter int QUEUE_DEPTH = 4,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  c0_valid,
    input  logic                  c0_is_branch,
    input  logic [ADDR_WIDTH-1:0] c0_pc,
    input  logic                  c0_taken,
    input  logic                  c0_pred_taken,
    input  logic [ADDR_WIDTH-1:0] c0_target,
    input  logic                  c1_valid,
    input  logic                  c1_is_branch,
    input  logic [ADDR_WIDTH-1:0] c1_pc,
    input  logic                  c1_taken,
    input  logic                  c1_pred_taken,
    input  logic [ADDR_WIDTH-1:0] c1_target,
    output logic                  commit_ready,
    output logic                  ROB_input_valid,
    output logic                  ROB_hit,
    output logic [ADDR_WIDTH-1:0] ROB_pc,
    output logic                  IF_flush,
    output logic [ADDR_WIDTH-1:0] IF_redirect_pc
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]           stat_branches,
    output logic [31:0]           stat_mispredicts
`endif
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0]  pc_mem [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] hit_mem;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic                  qual0;
    logic                  qual1;
    logic                  miss0;
    logic                  miss1;
    logic                  pop;
    logic [CNT_W-1:0]      push_n;
    logic [PTR_W-1:0]      wr1_ptr;
    logic [ADDR_WIDTH-1:0] redir0;
    logic [ADDR_WIDTH-1:0] redir1;

    // Two free slots are required so a dual-branch commit can never overflow.
    assign commit_ready = (count <= CNT_W'(QUEUE_DEPTH - 2));

    always_comb begin
        qual0   = c0_valid & c0_is_branch & commit_ready & rdy;
        miss0   = qual0 & (c0_taken ^ c0_pred_taken);
        // Slot 1 is on the wrong path once slot 0 mispredicts.
        qual1   = c1_valid & c1_is_branch & commit_ready & rdy & ~miss0;
        miss1   = qual1 & (c1_taken ^ c1_pred_taken);
        pop     = rdy & (count != '0);
        push_n  = CNT_W'(qual0) + CNT_W'(qual1);
        wr1_ptr = tail + PTR_W'(qual0);
        redir0  = c0_taken ? c0_target : c0_pc + ADDR_WIDTH'(4);
        redir1  = c1_taken ? c1_target : c1_pc + ADDR_WIDTH'(4);
    end

    always_ff @(posedge clk) begin
        if (qual0) begin
            pc_mem[tail]  <= c0_pc;
            hit_mem[tail] <= c0_taken;
        end
        if (qual1) begin
            pc_mem[wr1_ptr]  <= c1_pc;
            hit_mem[wr1_ptr] <= c1_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            ROB_input_valid <= 1'b0;
            ROB_hit         <= 1'b0;
            ROB_pc          <= '0;
            IF_flush        <= 1'b0;
            IF_redirect_pc  <= '0;
        end else if (rdy) begin
            head            <= head + PTR_W'(pop);
            tail            <= tail + PTR_W'(push_n);
            count           <= count + push_n - CNT_W'(pop);
            ROB_input_valid <= pop;
            if (pop) begin
                ROB_pc  <= pc_mem[head];
                ROB_hit <= hit_mem[head];
            end
            IF_flush <= miss0 | miss1;
            if (miss0) begin
                IF_redirect_pc <= redir0;
            end else if (miss1) begin
                IF_redirect_pc <= redir1;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    logic [32:0] br_sum;

    assign br_sum = {1'b0, stat_branches} + 33'(push_n);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (rdy) begin
            stat_branches <= br_sum[32] ? 32'hFFFF_FFFF : br_sum[31:0];
            if ((miss0 | miss1) && (stat_mispredicts != 32'hFFFF_FFFF)) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_commit_updater.sv
// Randomized scoreboard bench for branch_commit_updater (default build).
module tb_branch_commit_updater;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic        v;
        logic        b;
        logic        t;
        logic        p;
        logic [31:0] pc;
        logic [31:0] tg;
    } slot_t;

    typedef struct {
        int          e;
        int          kind;
        bit          v;
        logic [31:0] pc;
        bit          hit;
        bit          fl;
        logic [31:0] rd;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        c0_valid, c0_is_branch, c0_taken, c0_pred_taken;
    logic [31:0] c0_pc, c0_target;
    logic        c1_valid, c1_is_branch, c1_taken, c1_pred_taken;
    logic [31:0] c1_pc, c1_target;
    logic        commit_ready;
    logic        ROB_input_valid;
    logic        ROB_hit;
    logic [31:0] ROB_pc;
    logic        IF_flush;
    logic [31:0] IF_redirect_pc;

    branch_commit_updater #(.QUEUE_DEPTH(DEPTH), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .c0_valid(c0_valid), .c0_is_branch(c0_is_branch), .c0_pc(c0_pc),
        .c0_taken(c0_taken), .c0_pred_taken(c0_pred_taken), .c0_target(c0_target),
        .c1_valid(c1_valid), .c1_is_branch(c1_is_branch), .c1_pc(c1_pc),
        .c1_taken(c1_taken), .c1_pred_taken(c1_pred_taken), .c1_target(c1_target),
        .commit_ready(commit_ready), .ROB_input_valid(ROB_input_valid),
        .ROB_hit(ROB_hit), .ROB_pc(ROB_pc),
        .IF_flush(IF_flush), .IF_redirect_pc(IF_redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int tests = 0;
    int fails = 0;

    exp_t        sbq[$];
    logic [32:0] mq[$];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    function automatic slot_t br(logic [31:0] pc, logic t, logic p, logic [31:0] tg);
        slot_t s;
        s.v  = 1'b1;
        s.b  = 1'b1;
        s.t  = t;
        s.p  = p;
        s.pc = pc;
        s.tg = tg;
        return s;
    endfunction

    function automatic logic [31:0] redir(slot_t s);
        return s.t ? s.tg : s.pc + 32'd4;
    endfunction

    // Drive one cycle and record what the coming edge must produce.
    task automatic step(bit r, bit y, slot_t s0, slot_t s1);
        exp_t e;
        bit   ready;
        bit   m0;
        bit   m1;
        logic [32:0] ent;
        @(posedge clk);
        #1;
        rst = r;
        rdy = y;
        {c0_valid, c0_is_branch, c0_taken, c0_pred_taken, c0_pc, c0_target} = s0;
        {c1_valid, c1_is_branch, c1_taken, c1_pred_taken, c1_pc, c1_target} = s1;
        ready = (DEPTH - mq.size()) >= 2;
        chk("commit_ready", 64'(commit_ready), 64'(ready));
        e = '{e: edge_n + 1, kind: 0, v: 0, pc: '0, hit: 0, fl: 0, rd: '0};
        m0 = 0;
        m1 = 0;
        if (r) begin
            e.kind = 2;
            mq.delete();
        end else if (!y) begin
            e.kind = 1;
        end else begin
            if (mq.size() > 0) begin
                ent   = mq.pop_front();
                e.v   = 1;
                e.hit = ent[32];
                e.pc  = ent[31:0];
            end
            if (ready && s0.v && s0.b) begin
                mq.push_back({s0.t, s0.pc});
                m0 = (s0.t != s0.p);
            end
            if (ready && !m0 && s1.v && s1.b) begin
                mq.push_back({s1.t, s1.pc});
                m1 = (s1.t != s1.p);
            end
            e.fl = m0 || m1;
            e.rd = m0 ? redir(s0) : redir(s1);
        end
        sbq.push_back(e);
    endtask

    exp_t        me;
    logic        pv_v, pv_hit, pv_fl;
    logic [31:0] pv_pc, pv_rd;

    always @(negedge clk) begin
        if (sbq.size() > 0 && sbq[0].e == edge_n) begin
            me = sbq.pop_front();
            if (me.kind == 2) begin
                chk("reset_outputs",
                    64'({ROB_input_valid, ROB_hit, ROB_pc, IF_flush, IF_redirect_pc}), 64'd0);
            end else if (me.kind == 1) begin
                chk("stall_frozen",
                    64'({ROB_input_valid, ROB_hit, ROB_pc, IF_flush, IF_redirect_pc}),
                    64'({pv_v, pv_hit, pv_pc, pv_fl, pv_rd}));
            end else begin
                chk("update_valid", 64'(ROB_input_valid), 64'(me.v));
                if (me.v) begin
                    chk("update_pc", 64'(ROB_pc), 64'(me.pc));
                    chk("update_hit", 64'(ROB_hit), 64'(me.hit));
                end else begin
                    chk("update_hold", 64'({ROB_hit, ROB_pc}), 64'({pv_hit, pv_pc}));
                end
                chk("flush", 64'(IF_flush), 64'(me.fl));
                if (me.fl) chk("redirect", 64'(IF_redirect_pc), 64'(me.rd));
            end
            pv_v   = ROB_input_valid;
            pv_hit = ROB_hit;
            pv_pc  = ROB_pc;
            pv_fl  = IF_flush;
            pv_rd  = IF_redirect_pc;
        end
    end

    function automatic slot_t rnd_slot();
        slot_t s;
        s.v  = ($urandom % 10) < 7;
        s.b  = ($urandom % 10) < 7;
        s.t  = 1'($urandom);
        s.p  = (($urandom % 5) == 0) ? ~s.t : s.t;
        s.pc = $urandom & 32'hFFFF_FFFC;
        s.tg = $urandom & 32'hFFFF_FFFC;
        return s;
    endfunction

    slot_t z;

    initial begin
        z   = '0;
        rst = 1'b1;
        rdy = 1'b0;
        {c0_valid, c0_is_branch, c0_taken, c0_pred_taken, c0_pc, c0_target} = z;
        {c1_valid, c1_is_branch, c1_taken, c1_pred_taken, c1_pc, c1_target} = z;
        repeat (3) step(1, 0, z, z);

        step(0, 1, br(32'h100, 1, 1, 32'h500), z);
        repeat (3) step(0, 1, z, z);
        step(0, 1, br(32'h200, 0, 1, 32'h700), z);
        repeat (3) step(0, 1, z, z);
        step(0, 1, br(32'h300, 1, 0, 32'h400), br(32'h304, 1, 0, 32'h600));
        repeat (3) step(0, 1, z, z);
        step(0, 1, br(32'hFFFF_FFFC, 0, 1, 32'h10), z);
        repeat (3) step(0, 1, z, z);

        for (int i = 0; i < 6; i++)
            step(0, 1, br(32'h1000 + 32'(i) * 8, 1, 1, 0), br(32'h1004 + 32'(i) * 8, 0, 0, 0));
        repeat (6) step(0, 1, z, z);

        step(0, 1, br(32'h2000, 1, 1, 0), br(32'h2004, 0, 0, 0));
        step(0, 1, br(32'h2008, 0, 0, 0), br(32'h200C, 1, 1, 0));
        repeat (5) step(0, 0, br(32'h3000, 1, 1, 0), z);
        repeat (2) step(0, 1, z, z);
        step(1, 1, z, z);
        repeat (4) step(0, 1, z, z);

        for (int i = 0; i < 500; i++)
            step(($urandom % 80) == 0, ($urandom % 8) != 0, rnd_slot(), rnd_slot());

        repeat (8) step(0, 1, z, z);
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
